// File: rtl/mmio_wr_fifo.sv
// MMIO write-to-read circular FIFO with occupancy count and sticky overflow/underflow flags.
// Define MMIO_WR_FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered pop.
module mmio_wr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_evt;
  logic             w_udf_evt;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push    = wr_en && (!w_full || rd_en);
  assign w_pop     = rd_en && !w_empty;
  assign w_ovf_evt = wr_en && !w_push;
  assign w_udf_evt = rd_en && w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_evt)    r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_udf_evt)    r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

`ifdef MMIO_WR_FIFO_FWFT_EN
  logic [AW-1:0] w_rd_nxt;
  assign w_rd_nxt = r_rd_ptr + 1'b1;

  // Head copy: a push into an empty FIFO, or a push racing the pop of the last
  // entry, becomes the new head directly since memory is not yet written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_push && w_empty) begin
      r_rd_data <= wr_data;
    end else if (w_pop) begin
      r_rd_data <= (w_push && r_count == CW'(1)) ? wr_data : r_mem[w_rd_nxt];
    end
  end

  assign rd_valid = !w_empty;
`else
  logic r_rd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (w_pop)      r_rd_data <= r_mem[r_rd_ptr];
      else if (rd_en) r_rd_data <= '0;
    end
  end

  assign rd_valid = r_rd_valid;
`endif

  assign rd_data   = r_rd_data;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: doc/mmio_wr_fifo.md
Name: mmio_wr_fifo

Overview:
- Buffer between the AFU's MMIO write decode and the MMIO read mux.
- Each host MMIO write pushes one 64-bit word.
- Each host MMIO read of the data register pops one word and returns it.
- Circular-buffer FIFO with occupancy count, full/empty flags, and sticky overflow/underflow error flags readable over MMIO.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- CW, $clog2(DEPTH)+1, count width (derived localparam, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push request (driven from MMIO write valid with address match).
- wr_data  in  WIDTH  data to push.
- rd_en  in  1  pop request (driven from MMIO read valid with address match).
- rd_data  out  WIDTH  popped word.
- rd_valid  out  1  one-cycle pulse; rd_data is valid this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  current occupancy, 0..DEPTH.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky; a push was attempted while full.
- underflow  out  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset (async, rst high): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, empty=1, full=0. Storage array is not reset.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Push accepted when wr_en && (!full || rd_en):
  - Write mem[wr_ptr] <= wr_data.
  - Increment wr_ptr.
- Pop accepted when rd_en && !empty:
  - Register rd_data <= mem[rd_ptr], visible the next cycle together with rd_valid=1.
  - Increment rd_ptr.
  - Read latency is 1 cycle.
- Pop rejected (empty):
  - rd_valid=1 next cycle with rd_data=0, so the host always receives an MMIO response.
  - Set underflow.
- Push rejected (full and no pop accepted in the same cycle):
  - Data is dropped; wr_ptr is unchanged.
  - Set overflow.
- Simultaneous push and pop:
  - Not full and not empty: both accepted; count unchanged.
  - Full: pop frees the slot and push is accepted; count stays DEPTH; no overflow.
  - Empty: pop is rejected (no bypass) with underflow set and rd_data=0; push is accepted; count becomes 1.
- count: +1 on push-only, -1 on pop-only, unchanged otherwise. full and empty are derived combinationally from count.
- rd_valid deasserts the cycle after any pulse unless a new rd_en arrives.
- rd_data holds its last value when rd_valid=0.
- err_clr: clears overflow and underflow next cycle. If a new error event occurs in the same cycle, the set wins.
- Reset asserted mid-operation: all state returns to reset values immediately. An in-flight rd_valid is dropped.

Optional Feature:
- Macro: MMIO_WR_FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - rd_data continuously presents mem[rd_ptr] (registered copy updated on each push-to-empty and pop).
  - rd_valid = !empty.
  - rd_en acknowledges the displayed word and advances to the next entry.
  - Zero-latency view of the head.
  - Underflow behaviour is unchanged.
- Undefined: 1-cycle registered pop as described in Behaviour.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles → count=3, empty=0. Three pops → rd_valid pulses with rd_data 0x11, 0x22, 0x33, each 1 cycle after its rd_en; final count=0, empty=1.
- Push 8 words 0xA0..0xA7, then push 0xFF → full=1, count=8, overflow=1. Pops return 0xA0..0xA7; 0xFF is never returned.
- Pop while empty → rd_valid=1, rd_data=0, underflow=1. Pulse err_clr → underflow=0 next cycle.
- Fill to 8, then push 0xBB with simultaneous pop → pop returns the oldest word, count stays 8, overflow=0. Drain the FIFO; the last word returned is 0xBB.
- Wrap-around: 20 push/pop pairs with data = index → every pop returns the matching index and count never exceeds 1. Assert rst mid-sequence → count=0, rd_valid=0 immediately.
- With MMIO_WR_FIFO_FWFT_EN: push 0x55 → next cycle rd_valid=1 and rd_data=0x55 with no rd_en. Assert rd_en → rd_valid=0 and empty=1.
